// File: rtl/dmem_wait_responder_if.sv
// MEM-stage data bus between the pipeline (master) and the wait-state data memory (slave).
interface dmem_wait_responder_if #(
  parameter int WIDTH = 32
) ();
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] WD;
  logic             WE;
  logic             RE;
  logic [WIDTH-1:0] RD;
  logic             Stall;

  modport master (output A, WD, WE, RE, input  RD, Stall);
  modport slave  (input  A, WD, WE, RE, output RD, Stall);
endinterface

// File: rtl/dmem_wait_responder.sv
// Multi-cycle data memory for the MEM stage: holds the pipeline via Stall for
// LATENCY+1 cycles per access, then releases it for one DONE cycle.
module dmem_wait_responder #(
  parameter int WIDTH            = 32,
  parameter int DEPTH            = 100,
  parameter int LATENCY          = 2,
  parameter int Test_Value_width = 16
) (
  input  logic                        CLK,
  input  logic                        RST,
  dmem_wait_responder_if.slave        bus,
  output logic [Test_Value_width-1:0] Test_Value
);
  localparam int IDXW = $clog2(DEPTH);
  localparam int CW   = 4;
  localparam logic [IDXW:0]   DEPTH_W = (IDXW+1)'(DEPTH);
  localparam logic [CW-1:0]   CNT_INI = CW'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     count;
  logic [IDXW-1:0]   idx_q;
  logic [WIDTH-1:0]  wd_q;
  logic              we_q;
  logic [WIDTH-1:0]  rd_q;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic              req, stall, in_range;

  // Only the word index of the address is meaningful to this memory.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.A[WIDTH-1:IDXW+2], bus.A[1:0]};

  assign req      = bus.WE | bus.RE;
  assign in_range = {1'b0, idx_q} < DEPTH_W;

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    case (state)
      IDLE: begin
        stall = req;
        if (req) state_nxt = BUSY;
      end
      BUSY: begin
        stall = 1'b1;
        if (count == '0) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state <= IDLE;
      count <= '0;
      idx_q <= '0;
      wd_q  <= '0;
      we_q  <= 1'b0;
      rd_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (req) begin
          idx_q <= bus.A[IDXW+1:2];
          wd_q  <= bus.WD;
          we_q  <= bus.WE;
          count <= CNT_INI;
        end
        BUSY: begin
          if (count != '0) count <= count - 1'b1;
          else if (we_q) begin
            if (in_range) mem[idx_q] <= wd_q;
          end else begin
            // Out-of-range loads read as zero rather than aliasing.
            rd_q <= in_range ? mem[idx_q] : '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Stall must never hold the pipeline while reset is asserted.
  assign bus.Stall  = stall & RST;
  assign bus.RD     = rd_q;
  assign Test_Value = mem[0][Test_Value_width-1:0];
endmodule

// File: tb/tb_dmem_wait_responder.sv
// Bench for dmem_wait_responder: table-driven accesses on a LATENCY=2 instance,
// plus reset and back-to-back sequences on LATENCY=2 and LATENCY=1 instances.
module tb_dmem_wait_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] tv2, tv1;
  int          nvec = 0;
  int          nerr = 0;
  logic [31:0] sb [$];

  always #5 clk = ~clk;

  dmem_wait_responder_if #(.WIDTH(32)) b2 ();
  dmem_wait_responder_if #(.WIDTH(32)) b1 ();

  dmem_wait_responder #(.WIDTH(32), .DEPTH(100), .LATENCY(2), .Test_Value_width(16)) u2 (
    .CLK(clk), .RST(rst), .bus(b2), .Test_Value(tv2));
  dmem_wait_responder #(.WIDTH(32), .DEPTH(100), .LATENCY(1), .Test_Value_width(16)) u1 (
    .CLK(clk), .RST(rst), .bus(b1), .Test_Value(tv1));

  typedef struct {
    logic        we;
    logic        re;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic [15:0] exp_tv;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one request on the LATENCY=2 instance; scramble inputs while busy.
  task automatic req2(input logic we, input logic re, input logic [31:0] a,
                      input logic [31:0] wd, output int cnt);
    @(negedge clk);
    b2.WE = we; b2.RE = re; b2.A = a; b2.WD = wd;
    #1;
    cnt = 0;
    while (b2.Stall === 1'b1 && cnt < 20) begin
      cnt++;
      @(negedge clk);
      b2.A  = $urandom;
      b2.WD = $urandom;
      b2.WE = 1'($urandom_range(0, 1));
      b2.RE = 1'($urandom_range(0, 1));
      #1;
    end
    b2.WE = 1'b0; b2.RE = 1'b0; b2.A = '0; b2.WD = '0;
  endtask

  initial begin
    int          cnt;
    logic [31:0] e;
    logic        exp_st [6];

    tbl[0]  = '{1'b0, 1'b1, 32'h40,  32'h0,        32'h0,        16'h0};
    tbl[1]  = '{1'b1, 1'b0, 32'h8,   32'hDEADBEEF, 32'h0,        16'h0};
    tbl[2]  = '{1'b0, 1'b1, 32'h8,   32'h0,        32'hDEADBEEF, 16'h0};
    tbl[3]  = '{1'b1, 1'b0, 32'h0,   32'h1234ABCD, 32'hDEADBEEF, 16'hABCD};
    tbl[4]  = '{1'b0, 1'b1, 32'h3,   32'h0,        32'h1234ABCD, 16'hABCD};
    tbl[5]  = '{1'b1, 1'b0, 32'h190, 32'hFFFFFFFF, 32'h1234ABCD, 16'hABCD};
    tbl[6]  = '{1'b0, 1'b1, 32'h190, 32'h0,        32'h0,        16'hABCD};
    tbl[7]  = '{1'b0, 1'b1, 32'h18C, 32'h0,        32'h0,        16'hABCD};
    tbl[8]  = '{1'b1, 1'b1, 32'h8,   32'h11,       32'h0,        16'hABCD};
    tbl[9]  = '{1'b0, 1'b1, 32'h8,   32'h0,        32'h11,       16'hABCD};
    tbl[10] = '{1'b0, 1'b1, 32'h0,   32'h0,        32'h1234ABCD, 16'hABCD};

    b2.WE = 1'b0; b2.RE = 1'b0; b2.A = '0; b2.WD = '0;
    b1.WE = 1'b0; b1.RE = 1'b0; b1.A = '0; b1.WD = '0;

    // Reset for two cycles with a request pending: Stall must stay low.
    @(negedge clk);
    b2.WE = 1'b1;
    @(negedge clk);
    #1;
    chk("reset_stall", {31'b0, b2.Stall}, 32'h0);
    chk("reset_rd",    b2.RD, 32'h0);
    chk("reset_tv",    {16'h0, tv2}, 32'h0);
    chk("reset_rd_l1", b1.RD, 32'h0);
    b2.WE = 1'b0;
    rst = 1'b1;

    for (int i = 0; i < 11; i++) begin
      sb.push_back(tbl[i].exp_rd);
      req2(tbl[i].we, tbl[i].re, tbl[i].a, tbl[i].wd, cnt);
      e = sb.pop_front();
      chk($sformatf("v%0d_stall_cycles", i), cnt, 32'd3);
      chk($sformatf("v%0d_rd", i), b2.RD, e);
      chk($sformatf("v%0d_tv", i), {16'h0, tv2}, {16'h0, tbl[i].exp_tv});
      @(negedge clk);
      chk($sformatf("v%0d_idle_stall", i), {31'b0, b2.Stall}, 32'h0);
      chk($sformatf("v%0d_rd_hold", i), b2.RD, e);
    end

    // Reset in the first BUSY cycle of a store aborts it and clears memory.
    @(negedge clk);
    b2.WE = 1'b1; b2.A = 32'h4; b2.WD = 32'h55;
    @(negedge clk);
    b2.WE = 1'b0; b2.A = '0; b2.WD = '0;
    rst = 1'b0;
    #1;
    chk("midrst_stall", {31'b0, b2.Stall}, 32'h0);
    @(negedge clk);
    chk("midrst_stall2", {31'b0, b2.Stall}, 32'h0);
    chk("midrst_rd",     b2.RD, 32'h0);
    chk("midrst_tv",     {16'h0, tv2}, 32'h0);
    rst = 1'b1;
    req2(1'b0, 1'b1, 32'h4, 32'h0, cnt);
    chk("midrst_ld4_cycles", cnt, 32'd3);
    chk("midrst_ld4_rd", b2.RD, 32'h0);
    req2(1'b0, 1'b1, 32'h8, 32'h0, cnt);
    chk("midrst_ld8_rd", b2.RD, 32'h0);

    // LATENCY=1: store held through DONE, then a load right after.
    exp_st = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    @(negedge clk);
    b1.WE = 1'b1; b1.A = 32'hC; b1.WD = 32'h77;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("b2b_stall_%0d", k), {31'b0, b1.Stall}, {31'b0, exp_st[k]});
      if (k == 2) begin
        chk("b2b_rd_after_store", b1.RD, 32'h0);
        b1.WE = 1'b0; b1.RE = 1'b1;
        sb.push_back(32'h77);
      end
      if (k == 5) begin
        e = sb.pop_front();
        chk("b2b_load_rd", b1.RD, e);
        b1.RE = 1'b0; b1.A = '0; b1.WD = '0;
      end
      @(negedge clk);
    end
    #1;
    chk("b2b_idle_stall", {31'b0, b1.Stall}, 32'h0);
    chk("b2b_rd_hold",    b1.RD, 32'h77);
    chk("b2b_tv",         {16'h0, tv1}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
